reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Central reset controller for the SoC.
- Merges three reset sources:
  - the global asynchronous reset;
  - an asynchronous external reset pin, synchronized internally and debounced;
  - a synchronous software reset pulse.
- Releases DOMAINS downstream reset domains one at a time, in fixed order, with programmed spacing.
- Reports the cause of the last reset.

Parameters:
- DOMAINS, 4: number of reset domains; bit 0 is released first. Range 1..16.
- HOLD_CYCLES, 16: clock edges that all domains stay in reset after the source is removed. Must be >= 1.
- STEP_CYCLES, 8: clock edges between the release of domain i-1 and domain i. Must be >= 1.
- DEBOUNCE_CYCLES, 4: consecutive low samples of the synchronized external reset needed to trigger. Must be >= 1.
- SYNC_STAGES, 2: synchronizer flops on ext_rst_n_i. Must be >= 2.

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: global reset, asynchronous, active-high.
- ext_rst_n_i, input, 1: external reset pin, active-low, asynchronous to clk_i.
- sw_rst_i, input, 1: software reset request, single-cycle pulse, synchronous to clk_i.
- domain_rst_n_o, output, DOMAINS: per-domain reset, active-low, registered.
- ready_o, output, 1: all domains released; registered.
- cause_o, output, 2: cause of the last reset. 00 = global, 01 = external, 10 = software, 11 = unused.

Behaviour:
- Clocking and reset (already decided): one clock, clk_i. rst_i is asynchronous and active-high.
- While rst_i = 1:
  - domain_rst_n_o = 0 and ready_o = 0; cause_o = 00.
  - FSM = HOLD, hold and step counters = 0.
  - Synchronizer flops = 1 (deasserted); debounce counter = 0.
- All outputs come straight from flops, so they are glitch-free.
- FSM states: ASSERT, HOLD, RELEASE, RUN.
- HOLD:
  - Counts HOLD_CYCLES edges with all domains held in reset.
  - On the HOLD_CYCLES-th edge: domain_rst_n_o[0] goes to 1 and the FSM enters RELEASE. If DOMAINS = 1, it enters RUN directly and ready_o goes to 1 on the same edge.
- RELEASE:
  - Every STEP_CYCLES edges, the next domain bit is set.
  - Bits already released stay at 1, so domain_rst_n_o is always a thermometer code from bit 0 upward.
  - On the edge that sets bit DOMAINS-1: FSM enters RUN and ready_o goes to 1.
- Release latency:
  - From the first edge after rst_i deasserts to ready_o = 1: HOLD_CYCLES + (DOMAINS-1)*STEP_CYCLES edges.
  - With default parameters this is 40 edges.
- External reset path:
  - ext_rst_n_i passes through a SYNC_STAGES flop chain, reset value 1.
  - The debounce counter increments on each edge that samples the synchronized value low. It clears to 0 on any edge that samples it high, and saturates.
  - Trigger: the edge on which the synchronized value is low and the counter equals DEBOUNCE_CYCLES-1.
  - Trigger latency from a pin fall to outputs low: SYNC_STAGES + DEBOUNCE_CYCLES edges.
- On an external trigger, from any state:
  - On the trigger edge: domain_rst_n_o goes to 0, ready_o to 0, cause_o to 01; FSM enters ASSERT.
  - ASSERT persists while the synchronized value is low.
  - On the first edge that samples it high: FSM enters HOLD with the hold counter at 0.
- Low pulses shorter than DEBOUNCE_CYCLES samples are ignored entirely: no output change, no cause change.
- Software reset (sw_rst_i = 1 while the FSM is in HOLD, RELEASE or RUN):
  - On the next edge: all domains go to 0, ready_o to 0, cause_o to 10.
  - FSM enters HOLD with the hold and step counters cleared.
- sw_rst_i arriving during HOLD restarts the hold period.
- sw_rst_i is ignored while the FSM is in ASSERT.
- Simultaneous external trigger and sw_rst_i on the same edge: the external trigger wins and cause_o = 01.
- sw_rst_i held high for several cycles: each cycle re-clears the HOLD counters. Release starts HOLD_CYCLES edges after the last high cycle.
- rst_i asserted mid-operation: all outputs return immediately, asynchronously, to their reset values. The debounce and synchronizer state is lost.
- cause_o is sticky. It changes only on a new reset event and stays valid while ready_o = 1.

Test Plan:
- Power-on:
  - Stimulus: rst_i high for 3 cycles then low, default parameters.
  - Required: domain_rst_n_o = 0000 until edge 16, then 0001@16, 0011@24, 0111@32, 1111@40; ready_o = 1 at edge 40; cause_o = 00.
- Glitch rejection:
  - Stimulus: in RUN, ext_rst_n_i low for 3 cycles.
  - Required: no output change; cause_o stays 00.
- External press:
  - Stimulus: in RUN, ext_rst_n_i low for 12 cycles.
  - Required: all domains go to 0 exactly 6 edges after the pin falls; cause_o = 01; the release sequence restarts 16 edges after the synchronized rising edge; ready_o = 1 after 40 edges.
- Software reset mid-release:
  - Stimulus: sw_rst_i pulsed when domain_rst_n_o = 0011.
  - Required: next edge domain_rst_n_o = 0000, cause_o = 10; the full 40-edge sequence is repeated.
- Simultaneous events:
  - Stimulus: sw_rst_i pulsed on the same edge the debounce trigger fires.
  - Required: cause_o = 01; FSM enters ASSERT; the pulse has no further effect.
- Asynchronous reset mid-operation:
  - Stimulus: rst_i asserted between clock edges during RELEASE.
  - Required: outputs go to 0 and cause_o to 00 without waiting for a clock edge; the sequence then restarts normally.

Source files
------------

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Central SoC reset controller. Merges the global asynchronous
//            reset, a synchronized and debounced external reset pin, and a
//            synchronous software reset pulse. Releases DOMAINS reset domains
//            one at a time, bit 0 first, and reports the last reset cause.
// Ports    : clk_i          - system clock
//            rst_i          - global reset, asynchronous, active-high
//            ext_rst_n_i    - external reset pin, active-low, asynchronous
//            sw_rst_i       - software reset pulse, synchronous to clk_i
//            domain_rst_n_o - per-domain reset, active-low, registered
//            ready_o        - all domains released, registered
//            cause_o        - last reset cause: 00 global, 01 ext, 10 sw
// Revision : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int DOMAINS         = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int STEP_CYCLES     = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ext_rst_n_i,
  input  logic               sw_rst_i,
  output logic [DOMAINS-1:0] domain_rst_n_o,
  output logic               ready_o,
  output logic [1:0]         cause_o
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_SAT   = DW'(DEBOUNCE_CYCLES);

  localparam logic [1:0] CAUSE_GLOBAL = 2'b00;
  localparam logic [1:0] CAUSE_EXT    = 2'b01;
  localparam logic [1:0] CAUSE_SW     = 2'b10;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // External pin synchronizer and debounce
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          deb_cnt;
  logic                   ext_sync;
  logic                   ext_trig;

  assign ext_sync = sync_q[SYNC_STAGES-1];
  // Fires exactly once per press: the counter saturates one past the trigger
  // value, so a pin held low does not retrigger.
  assign ext_trig = !ext_sync && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '1;
      deb_cnt <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst_n_i};
      if (ext_sync) begin
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_SAT) begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Sequencing FSM
  // --------------------------------------------------------------------------
  state_t             state, state_n;
  logic [HW-1:0]      hold_cnt, hold_n;
  logic [SW-1:0]      step_cnt, step_n;
  logic [DOMAINS-1:0] dom_n, dom_step;
  logic               ready_n;
  logic [1:0]         cause_n;

  // Next thermometer value: shift the released bits up and fill bit 0.
  assign dom_step = (domain_rst_n_o << 1) | DOMAINS'(1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= ST_HOLD;
      hold_cnt       <= '0;
      step_cnt       <= '0;
      domain_rst_n_o <= '0;
      ready_o        <= 1'b0;
      cause_o        <= CAUSE_GLOBAL;
    end else begin
      state          <= state_n;
      hold_cnt       <= hold_n;
      step_cnt       <= step_n;
      domain_rst_n_o <= dom_n;
      ready_o        <= ready_n;
      cause_o        <= cause_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    step_n  = step_cnt;
    dom_n   = domain_rst_n_o;
    ready_n = ready_o;
    cause_n = cause_o;

    case (state)
      ST_ASSERT: begin
        if (ext_sync) begin
          state_n = ST_HOLD;
          hold_n  = '0;
          step_n  = '0;
        end
      end
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          hold_n = '0;
          step_n = '0;
          dom_n  = DOMAINS'(1);
          if (DOMAINS == 1) begin
            state_n = ST_RUN;
            ready_n = 1'b1;
          end else begin
            state_n = ST_RELEASE;
          end
        end else begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (step_cnt == STEP_LAST) begin
          step_n = '0;
          dom_n  = dom_step;
          if (dom_step[DOMAINS-1]) begin
            state_n = ST_RUN;
            ready_n = 1'b1;
          end
        end else begin
          step_n = step_cnt + 1'b1;
        end
      end
      default: begin
      end
    endcase

    // Software reset restarts the hold period from any non-ASSERT state.
    if (sw_rst_i && (state != ST_ASSERT)) begin
      state_n = ST_HOLD;
      hold_n  = '0;
      step_n  = '0;
      dom_n   = '0;
      ready_n = 1'b0;
      cause_n = CAUSE_SW;
    end

    // External trigger is evaluated last so it wins over a coincident sw pulse.
    if (ext_trig) begin
      state_n = ST_ASSERT;
      hold_n  = '0;
      step_n  = '0;
      dom_n   = '0;
      ready_n = 1'b0;
      cause_n = CAUSE_EXT;
    end
  end

endmodule
`default_nettype wire
